bus_simple_arb2: RTL and testbench

BUS_SIMPLE_ARB2 -- requirements
Module: bus_simple_arb2

---
 rtl/bus_simple_arb2.sv | 137 +++++++++++++
 tb/tb_bus_simple_arb2.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_simple_arb2.sv
// Two-requester round-robin arbiter onto one shared slave, one transaction in flight (IDLE/RESP).
// Define BUS_ARB_TIMEOUT_EN to add a RESP timeout that returns a forced response and pulses arb_timeout.
module bus_simple_arb2 #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_valid,
  input  logic        m0_write,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m1_valid,
  input  logic        m1_write,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic        s_valid,
  output logic        s_write,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  input  logic        s_rvalid,
  output logic        arb_owner,
  output logic        arb_busy
`ifdef BUS_ARB_TIMEOUT_EN
  ,
  output logic        arb_timeout
`endif
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 2..255");
  end

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   wr_q, wr_d;
  logic   last_grant_q, last_grant_d;

  logic grant, issue, in_resp, wr_rsp, rd_rsp, to_hit, done;
  logic rsp_ready, rsp_rvalid;
  logic [31:0] rsp_rdata;

  assign in_resp = (state_q == RESP);
  // On a tie the port that did not win last time goes next.
  assign grant   = (m0_valid && m1_valid) ? ~last_grant_q : m1_valid;
  assign issue   = rst_n && (state_q == IDLE) && (m0_valid || m1_valid);
  // Wrong-type responses fall through both terms and are dropped.
  assign wr_rsp  = in_resp && wr_q && s_ready;
  assign rd_rsp  = in_resp && !wr_q && s_rvalid;

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  assign to_hit      = in_resp && !wr_rsp && !rd_rsp && (cnt_q == 8'(TIMEOUT_CYCLES - 1));
  assign arb_timeout = rst_n && to_hit;
`else
  assign to_hit = 1'b0;
`endif

  assign done       = wr_rsp || rd_rsp || to_hit;
  assign rsp_ready  = rst_n && wr_q && (wr_rsp || to_hit);
  assign rsp_rvalid = rst_n && !wr_q && (rd_rsp || to_hit);
  assign rsp_rdata  = !rsp_rvalid ? 32'h0 : (rd_rsp ? s_rdata : 32'hDEAD_BEEF);

  assign m0_ready  = rsp_ready  && !owner_q;
  assign m0_rvalid = rsp_rvalid && !owner_q;
  assign m0_rdata  = owner_q ? 32'h0 : rsp_rdata;
  assign m1_ready  = rsp_ready  && owner_q;
  assign m1_rvalid = rsp_rvalid && owner_q;
  assign m1_rdata  = owner_q ? rsp_rdata : 32'h0;

  assign s_valid = issue;
  assign s_write = issue && (grant ? m1_write : m0_write);
  assign s_addr  = !issue ? 32'h0 : (grant ? m1_addr  : m0_addr);
  assign s_wdata = !issue ? 32'h0 : (grant ? m1_wdata : m0_wdata);
  assign s_wstrb = !issue ? 4'h0  : (grant ? m1_wstrb : m0_wstrb);

  assign arb_owner = owner_q;
  assign arb_busy  = rst_n && in_resp;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    last_grant_d = last_grant_q;
    if (issue) begin
      state_d      = RESP;
      owner_d      = grant;
      wr_d         = s_write;
      last_grant_d = grant;
    end else if (in_resp && done) begin
      state_d = IDLE;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_comb begin
    cnt_d = cnt_q;
    if (issue)
      cnt_d = 8'h0;
    else if (in_resp && !done)
      cnt_d = cnt_q + 8'h1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      last_grant_q <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q        <= 8'h0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      last_grant_q <= last_grant_d;
`ifdef BUS_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_bus_simple_arb2.sv
// Randomized and directed bench for bus_simple_arb2: per-cycle transaction-level model plus response scoreboard.
`timescale 1ns/1ps
module tb_bus_simple_arb2;
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int TO    = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 16;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]  m_valid, m_write, m_ready, m_rvalid;
  logic [31:0] m_addr[2], m_wdata[2], m_rdata[2];
  logic [3:0]  m_wstrb[2];
  logic        s_valid, s_write, s_ready, s_rvalid, arb_owner, arb_busy, arb_timeout;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  always #5 clk = ~clk;

  bus_simple_arb2 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_valid(m_valid[0]), .m0_write(m_write[0]), .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]),
    .m0_wstrb(m_wstrb[0]), .m0_ready(m_ready[0]), .m0_rdata(m_rdata[0]), .m0_rvalid(m_rvalid[0]),
    .m1_valid(m_valid[1]), .m1_write(m_write[1]), .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]),
    .m1_wstrb(m_wstrb[1]), .m1_ready(m_ready[1]), .m1_rdata(m_rdata[1]), .m1_rvalid(m_rvalid[1]),
    .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .arb_owner(arb_owner), .arb_busy(arb_busy)
`ifdef BUS_ARB_TIMEOUT_EN
    , .arb_timeout(arb_timeout)
`endif
  );
`ifndef BUS_ARB_TIMEOUT_EN
  assign arb_timeout = 1'b0;
`endif

  // lat = RESP cycle in which the slave answers (0 = never); stray = wrong-type response before that
  typedef struct {
    logic w; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb; logic [31:0] rdata;
    int lat; int gap; bit stray;
  } txn_t;
  typedef struct { logic port; logic w; logic [31:0] data; } exp_t;

  txn_t mq[2][$];
  exp_t sb[$];

  // reference model state
  bit   busy = 1'b0;
  logic owner_m = 1'b0, last_m = 1'b1;
  int   rcnt = 0;

  // expectations for the current cycle, consumed by the monitor
  logic        exp_sv = 1'b0, exp_sw = 1'b0, exp_busy = 1'b0, exp_owner = 1'b0, exp_to = 1'b0;
  logic [31:0] exp_sa = '0, exp_sd = '0;
  logic [3:0]  exp_ss = '0;
  logic [1:0]  exp_ready = '0, exp_rvalid = '0;
  bit          mon_en = 1'b0;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic add(input int p, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] st, input logic [31:0] rd, input int lat, input int gap,
                     input bit stray);
    txn_t t;
    t = '{w: w, addr: a, wdata: d, wstrb: st, rdata: rd, lat: lat, gap: gap, stray: stray};
    mq[p].push_back(t);
  endtask

  task automatic step();
    bit   pres[2];
    bit   done;
    logic g;
    txn_t cur, tmp;
    exp_t e;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      pres[p] = (mq[p].size() > 0) && (mq[p][0].gap == 0);
      if (pres[p]) begin
        m_valid[p] = 1'b1; m_write[p] = mq[p][0].w; m_addr[p] = mq[p][0].addr;
        m_wdata[p] = mq[p][0].wdata; m_wstrb[p] = mq[p][0].wstrb;
      end else begin
        m_valid[p] = 1'b0; m_write[p] = 1'($urandom); m_addr[p] = $urandom;
        m_wdata[p] = $urandom; m_wstrb[p] = 4'($urandom);
      end
    end
    s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = $urandom;
    exp_sv = 1'b0; exp_ready = '0; exp_rvalid = '0; exp_to = 1'b0;
    exp_busy = busy; exp_owner = owner_m;
    if (busy) begin
      cur = mq[owner_m][0];
      rcnt++;
      done = 1'b0;
      if (cur.lat != 0 && rcnt == cur.lat) begin
        if (cur.w) s_ready = 1'b1;
        else begin s_rvalid = 1'b1; s_rdata = cur.rdata; end
        done = 1'b1;
      end else if (TO_EN && rcnt == TO) begin
        done = 1'b1; exp_to = 1'b1;
      end else if (cur.stray) begin
        if (cur.w) s_rvalid = 1'b1; else s_ready = 1'b1;
      end
      if (done) begin
        if (cur.w) exp_ready[owner_m] = 1'b1; else exp_rvalid[owner_m] = 1'b1;
        void'(mq[owner_m].pop_front());
        busy = 1'b0;
      end
    end else if (pres[0] || pres[1]) begin
      g = (pres[0] && pres[1]) ? ~last_m : pres[1];
      cur = mq[g][0];
      exp_sv = 1'b1; exp_sw = cur.w; exp_sa = cur.addr; exp_sd = cur.wdata; exp_ss = cur.wstrb;
      e = '{port: g, w: cur.w, data: cur.rdata};
      sb.push_back(e);
      busy = 1'b1; rcnt = 0; owner_m = g; last_m = g;
    end
    for (int p = 0; p < 2; p++)
      if (!pres[p] && mq[p].size() > 0 && mq[p][0].gap > 0) begin
        tmp = mq[p][0]; tmp.gap--; mq[p][0] = tmp;
      end
  endtask

  task automatic run(input int budget);
    int n = 0;
    while ((mq[0].size() > 0 || mq[1].size() > 0 || busy) && n < budget) begin
      step(); n++;
    end
    if (n >= budget) begin
      miscompares++;
      $display("FAIL run_budget: %0d cycles spent, transactions still pending", n);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end
    step();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {22'h0, m_ready, m_rvalid, s_valid, s_write, s_wstrb, arb_owner, arb_busy},
        32'h0);
    chk({nm, "_rdata"}, m_rdata[0] | m_rdata[1], 32'h0);
    chk({nm, "_spay"}, s_addr | s_wdata, 32'h0);
    chk({nm, "_to"}, 32'(arb_timeout), 32'h0);
  endtask

  // monitor / scoreboard
  initial forever begin
    exp_t e;
    bit   have;
    @(negedge clk);
    #2;
    if (mon_en) begin
      chk("s_valid", 32'(s_valid), 32'(exp_sv));
      if (exp_sv) begin
        chk("s_write", 32'(s_write), 32'(exp_sw));
        chk("s_addr", s_addr, exp_sa);
        chk("s_wdata", s_wdata, exp_sd);
        chk("s_wstrb", 32'(s_wstrb), 32'(exp_ss));
      end else begin
        chk("s_idle_payload", s_addr | s_wdata | {27'h0, s_wstrb, s_write}, 32'h0);
      end
      chk("arb_busy", 32'(arb_busy), 32'(exp_busy));
      chk("arb_owner", 32'(arb_owner), 32'(exp_owner));
      chk("m_ready", 32'(m_ready), 32'(exp_ready));
      chk("m_rvalid", 32'(m_rvalid), 32'(exp_rvalid));
      chk("arb_timeout", 32'(arb_timeout), 32'(exp_to));
      have = 1'b0;
      if (|m_ready || |m_rvalid) begin
        if (sb.size() == 0) chk("sb_unexpected_rsp", 32'h1, 32'h0);
        else begin
          e = sb.pop_front(); have = 1'b1;
          chk("rsp_port", 32'(m_ready[1] | m_rvalid[1]), 32'(e.port));
          chk("rsp_type", 32'(|m_ready), 32'(e.w));
        end
      end
      for (int p = 0; p < 2; p++)
        chk("m_rdata", m_rdata[p],
            (have && !e.w && e.port == 1'(p) && m_rvalid[p]) ? e.data : 32'h0);
    end
  end

  initial begin
    m_valid = 2'b11; m_write = 2'b00; s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h1234;
    for (int p = 0; p < 2; p++) begin
      m_addr[p] = 32'hFFFF_0000; m_wdata[p] = 32'h1; m_wstrb[p] = 4'hF;
    end
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    m_valid = 2'b00;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // simultaneous reads right after reset: m0 first, then m1
    add(0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hA5A5_0000, 1, 0, 1'b0);
    add(1, 1'b0, 32'h200, 32'h0, 4'h0, 32'h5A5A_1111, 1, 0, 1'b0);
    run(20);

    // lone m0 write, nominal 1-cycle slave
    add(0, 1'b1, 32'h10, 32'h1234_5678, 4'hF, 32'h0, 1, 0, 1'b0);
    run(20);

    // both continuously valid: 8 back-to-back 2-cycle transactions alternating
    for (int i = 0; i < 4; i++) begin
      add(0, 1'($urandom), $urandom, $urandom, 4'($urandom), $urandom, 1, 0, 1'b0);
      add(1, 1'($urandom), $urandom, $urandom, 4'($urandom), $urandom, 1, 0, 1'b0);
    end
    run(40);

    // stray s_rvalid on a write, s_ready one cycle later
    add(1, 1'b1, 32'h40, 32'hCAFE_F00D, 4'h3, 32'h0, 2, 0, 1'b1);
    run(20);

`ifdef BUS_ARB_TIMEOUT_EN
    add(1, 1'b0, 32'h80, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    run(20);
`endif

    for (int i = 0; i < 60; i++)
      for (int p = 0; p < 2; p++)
        add(p, 1'($urandom), $urandom, $urandom, 4'($urandom), $urandom,
            int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    run(2000);

    // reset in the middle of RESP
    add(0, 1'b1, 32'h50, 32'h5555_AAAA, 4'hF, 32'h0, 3, 0, 1'b0);
    step();
    step();
    #3;
    mon_en = 1'b0;
    m_valid[1] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_resp");
    @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    m_valid = 2'b00; rst_n = 1'b1;
    busy = 1'b0; owner_m = 1'b0; last_m = 1'b1; rcnt = 0;
    sb.delete(); mq[0].delete(); mq[1].delete();
    exp_sv = 1'b0; exp_ready = '0; exp_rvalid = '0; exp_busy = 1'b0; exp_owner = 1'b0;
    exp_to = 1'b0;
    mon_en = 1'b1;
    add(0, 1'b0, 32'h60, 32'h0, 4'h0, 32'h0BAD_F00D, 1, 0, 1'b0);
    add(1, 1'b1, 32'h70, 32'h7777_0000, 4'hC, 32'h0, 1, 0, 1'b0);
    run(20);

    @(negedge clk);
    mon_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
